seconds_tick_gen: RTL and testbench
===================================

Name: seconds_tick_gen

Overview:
Upstream stage of the clock datapath. Divides the system clock down to a 1 Hz tick and counts seconds 0-59. On each 59->0 wrap it produces the minute-advance strobe that clocks the minutes counter. The strobe is a clean, registered, stretched pulse, so the downstream counter sees exactly one rising edge per minute.

Parameters:
CLK_FREQ_HZ, 50000000, system clock cycles per second (prescaler terminal count + 1); must be >= 2
INC_PULSE_CYC, 4, high time of o_inc_min in clk cycles; 1 <= INC_PULSE_CYC < CLK_FREQ_HZ
PRESC_W, 26, prescaler width; must satisfy 2^PRESC_W >= CLK_FREQ_HZ

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
i_run  input  1  count enable; prescaler and seconds hold when low
i_clr  input  1  synchronous clear of prescaler, seconds and strobe
o_sec  output  6  current seconds, 0-59, registered
o_tick_1hz  output  1  one-clk pulse in the cycle o_sec advances
o_inc_min  output  1  minute-advance strobe to the minutes stage, high INC_PULSE_CYC cycles

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, o_sec=0, o_tick_1hz=0, o_inc_min=0, stretch counter=0. All outputs go low/zero immediately, including mid-pulse.
- Priority per edge: i_clr > (optional set) > i_run.
- Prescaler: counts 0..CLK_FREQ_HZ-1 while i_run=1. When prescaler==CLK_FREQ_HZ-1 and i_run=1, the next edge does all of the following together:
  - sets prescaler to 0
  - sets o_tick_1hz=1 for that one cycle
  - advances o_sec
- Tick period is exactly CLK_FREQ_HZ cycles of i_run=1. The first tick comes CLK_FREQ_HZ edges after i_run rises from a cleared state.
- Seconds: on a tick, o_sec increments. When o_sec==59, it goes to 0 on the same edge and o_inc_min rises on that edge.
- Strobe: o_inc_min is registered, stays high for exactly INC_PULSE_CYC cycles, then goes low. It uses a down-counter loaded with INC_PULSE_CYC.
  - The next wrap is at least CLK_FREQ_HZ cycles later, so the strobe never re-triggers while high.
- i_run=0: prescaler and o_sec hold and o_tick_1hz=0. A strobe already in progress still completes its full width.
- i_clr=1: on the next edge, prescaler=0, o_sec=0, o_tick_1hz=0, o_inc_min=0 and the stretch counter is cleared, aborting any pulse.
  - A clear that coincides with a would-be 59->0 wrap produces no tick and no strobe.
- All arithmetic is unsigned. o_sec never holds a value above 59.

Optional Feature:
Macro SEC_SET_EN.
- When defined, adds two ports:
  - i_set  input  1  synchronous load strobe
  - i_set_sec  input  6  load value
- Behaviour of a load, when i_set=1 and i_clr=0:
  - Next edge sets o_sec=i_set_sec, saturating values >59 to 59.
  - The prescaler goes to 0.
  - o_tick_1hz=0; no strobe is started.
  - A strobe already in progress completes its full width.
- A load has priority over i_run.
- When the macro is undefined, these ports do not exist and the behaviour is as above.

Test Plan:
All scenarios use CLK_FREQ_HZ=10, INC_PULSE_CYC=3.
1. Release reset, hold i_run=1 -> first o_tick_1hz exactly 10 clk later with o_sec=1 in the same cycle; ticks every 10 clk; o_tick_1hz always 1 cycle wide.
2. Run 600 clk from clear -> o_sec goes 59->0 at clk 600; o_inc_min high exactly 3 cycles starting that edge; exactly one o_inc_min rising edge per 600 clk over 3 minutes.
3. Drop i_run when prescaler=4, hold low 7 clk, reassert -> next tick delayed by exactly 7 clk; o_sec unchanged during the pause; a strobe that was in progress still lasts 3 cycles.
4. Assert i_clr on the cycle where o_sec=59 and prescaler=9 with i_run=1 -> o_sec=0, no o_tick_1hz, no o_inc_min; the next tick comes 10 clk after i_clr drops.
5. Pull rst_n low in the 2nd cycle of an o_inc_min pulse -> o_inc_min, o_tick_1hz and o_sec go to 0 immediately, without waiting for a clk edge; after release, counting restarts from 0.
6. SEC_SET_EN: i_set with i_set_sec=45 -> o_sec=45 next cycle, first o_inc_min 150 clk later. i_set_sec=63 -> o_sec=59. i_set together with i_clr -> o_sec=0.

Source files
------------

// File: rtl/seconds_tick_gen.sv
// Divides clk to a 1 Hz tick, counts seconds 0-59 and emits a stretched minute-advance strobe.
// Optional `SEC_SET_EN adds a synchronous seconds load (i_set / i_set_sec).
module seconds_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int unsigned INC_PULSE_CYC = 4,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_clr,
`ifdef SEC_SET_EN
  input  logic       i_set,
  input  logic [5:0] i_set_sec,
`endif
  output logic [5:0] o_sec,
  output logic       o_tick_1hz,
  output logic       o_inc_min
);

  localparam int unsigned        StrW     = $clog2(INC_PULSE_CYC + 1);
  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(CLK_FREQ_HZ - 1);
  localparam logic [PRESC_W-1:0] PrescOne = PRESC_W'(1);
  localparam logic [5:0]         SecMax   = 6'd59;
  localparam logic [StrW-1:0]    StrLoad  = StrW'(INC_PULSE_CYC);
  localparam logic [StrW-1:0]    StrOne   = StrW'(1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic               tick_q, tick_d;
  logic               inc_q, inc_d;
  logic [StrW-1:0]    str_q, str_d;

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    inc_d   = inc_q;
    str_d   = str_q;

    // Strobe runs down regardless of i_run or a load; only a clear aborts it.
    if (str_q != '0) begin
      str_d = str_q - StrOne;
      inc_d = (str_q > StrOne);
    end

    if (i_clr) begin
      presc_d = '0;
      sec_d   = '0;
      inc_d   = 1'b0;
      str_d   = '0;
    end
`ifdef SEC_SET_EN
    else if (i_set) begin
      presc_d = '0;
      sec_d   = (i_set_sec > SecMax) ? SecMax : i_set_sec;
    end
`endif
    else if (i_run) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q >= SecMax) begin
          sec_d = '0;
          inc_d = 1'b1;
          str_d = StrLoad;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PrescOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
      inc_q   <= 1'b0;
      str_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      inc_q   <= inc_d;
      str_q   <= str_d;
    end
  end

  assign o_sec      = sec_q;
  assign o_tick_1hz = tick_q;
  assign o_inc_min  = inc_q;

endmodule

// File: tb/tb_seconds_tick_gen.sv
// Self-checking bench for seconds_tick_gen: vector table, corner sequences, random vs model.
// Set-load scenarios are compiled in when SEC_SET_EN is defined.
module tb_seconds_tick_gen;

  localparam int unsigned Clk = 10;
  localparam int unsigned Inc = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       clr;
`ifdef SEC_SET_EN
  logic       set;
  logic [5:0] set_sec;
`endif
  logic [5:0] sec;
  logic       tick;
  logic       inc;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_total = seconds * Clk + cycles into the current second.
  int m_total;
  int m_left;
  bit m_tick;

  typedef struct {
    bit run;
    bit clr;
    int ncyc;
    int sec;
    bit tick;
    bit inc;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  seconds_tick_gen #(
    .CLK_FREQ_HZ  (Clk),
    .INC_PULSE_CYC(Inc),
    .PRESC_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (run),
    .i_clr     (clr),
`ifdef SEC_SET_EN
    .i_set     (set),
    .i_set_sec (set_sec),
`endif
    .o_sec     (sec),
    .o_tick_1hz(tick),
    .o_inc_min (inc)
  );

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  task automatic model_reset();
    m_total = 0;
    m_left  = 0;
    m_tick  = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    if (clr) begin
      m_total = 0;
      m_left  = 0;
    end
`ifdef SEC_SET_EN
    else if (set) begin
      m_total = ((set_sec > 59) ? 59 : int'(set_sec)) * Clk;
      if (m_left > 0) m_left--;
    end
`endif
    else begin
      if (m_left > 0) m_left--;
      if (run) begin
        m_total = (m_total + 1) % (60 * Clk);
        m_tick  = (m_total % Clk) == 0;
        if (m_total == 0) m_left = Inc;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model();
    chk("rnd_sec", int'(sec), m_total / Clk);
    chk("rnd_tick", int'(tick), int'(m_tick));
    chk("rnd_inc", int'(inc), int'(m_left > 0));
  endtask

  task automatic do_clr();
    run = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int rises;
    int first_rise;
    bit prev;

    rst_n = 1'b0;
    run   = 1'b0;
    clr   = 1'b0;
`ifdef SEC_SET_EN
    set     = 1'b0;
    set_sec = '0;
`endif
    model_reset();
    #12;
    chk("rst_sec", int'(sec), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_inc", int'(inc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First tick 10 edges after run, then every 10, one cycle wide.
    run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("p1_tick", int'(tick), int'(i % 10 == 0));
      if (i == 10) chk("p1_sec", int'(sec), 1);
    end

    vecs[0] = '{run: 1, clr: 0, ncyc: 9,  sec: 0, tick: 0, inc: 0};
    vecs[1] = '{run: 1, clr: 0, ncyc: 1,  sec: 1, tick: 1, inc: 0};
    vecs[2] = '{run: 1, clr: 0, ncyc: 1,  sec: 1, tick: 0, inc: 0};
    vecs[3] = '{run: 0, clr: 0, ncyc: 5,  sec: 1, tick: 0, inc: 0};
    vecs[4] = '{run: 1, clr: 0, ncyc: 9,  sec: 2, tick: 1, inc: 0};
    vecs[5] = '{run: 1, clr: 1, ncyc: 1,  sec: 0, tick: 0, inc: 0};
    vecs[6] = '{run: 1, clr: 0, ncyc: 10, sec: 1, tick: 1, inc: 0};
    do_clr();
    for (int v = 0; v < 7; v++) begin
      run = vecs[v].run;
      clr = vecs[v].clr;
      repeat (vecs[v].ncyc) step();
      chk($sformatf("vec%0d_sec", v), int'(sec), vecs[v].sec);
      chk($sformatf("vec%0d_tick", v), int'(tick), int'(vecs[v].tick));
      chk($sformatf("vec%0d_inc", v), int'(inc), int'(vecs[v].inc));
    end
    clr = 1'b0;

    // Three minutes: wrap at 600, strobe 3 wide, one rising edge per minute.
    do_clr();
    run        = 1'b1;
    rises      = 0;
    first_rise = -1;
    prev       = 1'b0;
    for (int i = 1; i <= 1800; i++) begin
      step();
      if (inc && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = i;
      end
      prev = inc;
      if (i == 599) chk("p2_sec59", int'(sec), 59);
      if (i == 600) chk("p2_sec_wrap", int'(sec), 0);
      if (i >= 599 && i <= 603) chk("p2_inc_width", int'(inc), int'(i >= 600 && i <= 602));
    end
    chk("p2_rises", rises, 3);
    chk("p2_first_rise", first_rise, 600);

    // Pause at prescaler 4 for 7 edges delays the tick by 7.
    do_clr();
    run = 1'b1;
    repeat (4) step();
    run = 1'b0;
    repeat (7) step();
    chk("p3_pause_sec", int'(sec), 0);
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("p3_tick", int'(tick), int'(i == 6));
    end
    chk("p3_sec", int'(sec), 1);

    // Strobe in progress finishes while run is low.
    do_clr();
    run = 1'b1;
    repeat (600) step();
    run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("p3_strobe", int'(inc), int'(i <= 2));
      chk("p3_strobe_sec", int'(sec), 0);
    end

    // Clear on the would-be wrap edge.
    do_clr();
    run = 1'b1;
    repeat (599) step();
    chk("p4_sec59", int'(sec), 59);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("p4_sec", int'(sec), 0);
    chk("p4_tick", int'(tick), 0);
    chk("p4_inc", int'(inc), 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("p4_next_tick", int'(tick), int'(i == 10));
    end

    // Asynchronous reset in the second cycle of a strobe, then mid-minute.
    do_clr();
    run = 1'b1;
    repeat (601) step();
    chk("p5_inc_pre", int'(inc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("p5_inc", int'(inc), 0);
    chk("p5_tick", int'(tick), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (75) step();
    chk("p5_sec_pre", int'(sec), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("p5_sec", int'(sec), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("p5_restart_tick", int'(tick), int'(i == 10));
    end
    chk("p5_restart_sec", int'(sec), 1);

`ifdef SEC_SET_EN
    do_clr();
    set     = 1'b1;
    set_sec = 6'd45;
    step();
    set = 1'b0;
    chk("p6_set45", int'(sec), 45);
    run        = 1'b1;
    first_rise = -1;
    prev       = 1'b0;
    for (int i = 1; i <= 160; i++) begin
      step();
      if (inc && !prev && first_rise < 0) first_rise = i;
      prev = inc;
    end
    chk("p6_first_inc", first_rise, 150);
    set     = 1'b1;
    set_sec = 6'd63;
    step();
    chk("p6_sat", int'(sec), 59);
    clr = 1'b1;
    step();
    chk("p6_set_clr", int'(sec), 0);
    set = 1'b0;
    clr = 1'b0;
`endif

    // Random run/clear (and load) against the model.
    do_clr();
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 299) == 0);
`ifdef SEC_SET_EN
      set     = ($urandom_range(0, 399) == 0);
      set_sec = 6'($urandom_range(0, 63));
`endif
      step();
      cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
